obj_line_buffer_pp: RTL and testbench
=====================================

Name: obj_line_buffer_pp

Overview:
Parametrised ping-pong OBJ line buffer for the sprite pipeline, replacing the fixed 240-column double buffer. The renderer writes the back bank with per-pixel priority resolution. The compositor reads the front bank with registered 1-cycle latency. Banks swap on a line strobe, and the new back bank is cleared by a sequential engine at one column per cycle, not by a single-cycle flash clear.

Parameters:
DATA_W, 20, pixel word width (colour index plus attribute bits)
COLS, 240, columns per line
PRIO_W, 2, OBJ priority width; lower value = higher priority
STICKY_BIT, 14, attribute bit OR-accumulated across writes (OBJ-window flag)
CW, $clog2(COLS), column index width (derived; not overridden)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
swap  in  1  single-cycle line-boundary strobe; exchanges front/back banks
we  in  1  write request to back bank
wcol  in  CW  write column
wdata  in  DATA_W  pixel word
wprio  in  PRIO_W  priority of incoming pixel
transparent  in  1  force incoming pixel transparent
palettemode  in  1  0 = 16-colour (transparent if wdata[3:0]==0), 1 = 256-colour (transparent if wdata[7:0]==0)
wready  out  1  back bank accepts writes (clear engine idle)
rcol  in  CW  read column, front bank
rdata  out  DATA_W  registered front-bank pixel
rprio  out  PRIO_W  registered front-bank priority
busy  out  1  clear engine active
overrun  out  1  one-cycle pulse: swap arrived while clearing

Behaviour:
- One clock, synchronous active-high reset. Reset values: rdata=0, rprio=all-ones, wready=0, busy=1, overrun=0, front_sel=0. State goes to INIT_CLR.
- Entry content is {data, prio}. Cleared entry = {0, all-ones}.
- FSM states:
  - INIT_CLR: clears both banks together, col counter 0..COLS-1, one column per cycle. Takes COLS cycles, then IDLE. Swaps are ignored and do not raise overrun.
  - IDLE: wready=1, busy=0. swap -> toggle front_sel, counter=0, go to CLEAR.
  - CLEAR: clears back bank column counter, increments. Leaves after col COLS-1, so COLS cycles total. wready=0, busy=1.
- swap in CLEAR: pulse overrun, toggle front_sel, restart counter at 0 on the new back bank. The abandoned partial clear is not completed.
- Write accepted when we & wready. wcol >= COLS: write dropped.
- Write rule: the incoming pixel is non-transparent if ~transparent and it is non-zero under palettemode. It updates the entry when stored data is transparent (same palettemode test) or wprio < stored prio. On equal priority, the earlier writer wins.
- On update, new data = wdata with bit STICKY_BIT ORed from stored data. On a non-updating accepted write, only STICKY_BIT is ORed in.
- Write in the same cycle as swap lands in the pre-swap back bank, which becomes front. The write/swap decision uses pre-edge state.
- Read: rdata/rprio registered from front bank at rcol, 1-cycle latency. rcol >= COLS -> rdata=0, rprio=all-ones.
- Front bank contents are never modified except by INIT_CLR.
- Write path is a combinational read-modify-write of one entry. One write per cycle.

Decomposition:
- Package obj_pkg:
  - typedef obj_px_t {data, prio}
  - constant OBJ_PX_CLEAR
  - function obj_is_transparent(data, palettemode)
  - enum obj_lb_state_e {INIT_CLR, IDLE, CLEAR}
- Sub-module obj_line_bank holds one bank: COLS entries with a write port, a clear port and an async read. It is instantiated twice. Priority/sticky merge logic lives in the top level.

Test Plan:
- Reset, run COLS=240 cycles -> busy=1 and wready=0 for exactly 240 cycles. Then busy=0, all rdata=0, rprio=3.
- Write col 10 data 0x00012 prio 2, then col 10 data 0x00034 prio 1, then 0x00056 prio 1. Swap, wait 240 cycles, read col 10 -> 0x00034, prio 1, 1-cycle latency.
- palettemode=0: write col 5 data 0x00010 (low nibble 0) -> entry stays 0. palettemode=1: same data -> written.
- Write col 7 data 0x04000 | 0x00001 prio 3, then 0x00022 prio 0 -> final 0x04022.
- Swap at cycle 100 of a CLEAR -> overrun pulses once and busy stays high 240 more cycles. Write with we during CLEAR -> ignored.
- rcol=240 and rcol=255 -> rdata=0. Write wcol=250 -> no bank entry changes.

Source files
------------

// File: rtl/obj_pkg.sv
// obj_pkg: shared OBJ line buffer types, constants and pixel helpers
package obj_pkg;
  localparam int OBJ_DATA_W = 20;
  localparam int OBJ_PRIO_W = 2;
  typedef struct packed {
    logic [OBJ_DATA_W-1:0] data;
    logic [OBJ_PRIO_W-1:0] prio;
  } obj_px_t;
  localparam obj_px_t OBJ_PX_CLEAR = '{data: '0, prio: '1};
  typedef enum logic [1:0] {INIT_CLR, IDLE, CLEAR} obj_lb_state_e;
  function automatic logic obj_is_transparent(input logic [7:0] data, input logic palettemode);
    return palettemode ? (data == 8'd0) : (data[3:0] == 4'd0);
  endfunction
endpackage

// File: rtl/obj_line_bank.sv
// obj_line_bank: one line of OBJ pixel entries with write, clear and async read ports
module obj_line_bank #(
  parameter int W = 22,
  parameter int COLS = 240,
  parameter int CW = 8,
  parameter logic [W-1:0] CLR = '0
) (
  input  logic          clock,
  input  logic          we,
  input  logic          clr,
  input  logic [CW-1:0] wcol,
  input  logic [CW-1:0] ccol,
  input  logic [CW-1:0] raddr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [COLS];
  // Clear wins over a write; the controller never asks for both at once.
  always_ff @(posedge clock) begin
    if (clr) r_mem[ccol] <= CLR;
    else if (we) r_mem[wcol] <= wdata;
  end
  assign rdata = (int'(raddr) < COLS) ? r_mem[raddr] : CLR;
endmodule

// File: rtl/obj_line_buffer_pp.sv
// obj_line_buffer_pp: ping-pong OBJ line buffer with priority merge and sequential back-bank clear
module obj_line_buffer_pp
  import obj_pkg::*;
#(
  parameter int DATA_W = OBJ_DATA_W,
  parameter int COLS = 240,
  parameter int PRIO_W = OBJ_PRIO_W,
  parameter int STICKY_BIT = 14,
  localparam int CW = $clog2(COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              swap,
  input  logic              we,
  input  logic [CW-1:0]     wcol,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PRIO_W-1:0] wprio,
  input  logic              transparent,
  input  logic              palettemode,
  output logic              wready,
  input  logic [CW-1:0]     rcol,
  output logic [DATA_W-1:0] rdata,
  output logic [PRIO_W-1:0] rprio,
  output logic              busy,
  output logic              overrun
);
  localparam int EW = DATA_W + PRIO_W;
  localparam logic [EW-1:0] PX_CLR = {{DATA_W{1'b0}}, {PRIO_W{1'b1}}};
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PRIO_W-1:0] prio;
  } px_t;
  obj_lb_state_e r_state, w_state_nx;
  logic [CW-1:0] r_col, w_col_nx;
  logic r_front, w_front_nx, r_overrun, w_ovr_nx, w_acc, w_upd;
  logic [1:0] w_clr, w_we;
  logic [CW-1:0] w_raddr [2];
  logic [EW-1:0] w_rd [2];
  logic [EW-1:0] r_rd;
  px_t w_old, w_new;
  assign wready = r_state == IDLE;
  assign busy = ~wready;
  assign overrun = r_overrun;
  assign {rdata, rprio} = r_rd;
  assign w_acc = we & wready & (int'(wcol) < COLS);
  assign w_we = w_acc ? (r_front ? 2'b01 : 2'b10) : 2'b00;
  assign w_old = r_front ? w_rd[0] : w_rd[1];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_raddr[b] = (r_front == 1'(b)) ? rcol : wcol;
    obj_line_bank #(.W(EW), .COLS(COLS), .CW(CW), .CLR(PX_CLR)) u_bank (
      .clock (clock),
      .we    (w_we[b]),
      .clr   (w_clr[b]),
      .wcol  (wcol),
      .ccol  (r_col),
      .raddr (w_raddr[b]),
      .wdata (w_new),
      .rdata (w_rd[b])
    );
  end
  // Opaque pixels replace transparent or lower-priority entries; the window bit always accumulates.
  always_comb begin
    w_upd = ~transparent & ~obj_is_transparent(wdata[7:0], palettemode)
          & (obj_is_transparent(w_old.data[7:0], palettemode) | (wprio < w_old.prio));
    w_new = w_upd ? px_t'({wdata, wprio}) : w_old;
    w_new.data[STICKY_BIT] = wdata[STICKY_BIT] | w_old.data[STICKY_BIT];
  end
  // Clear engine: both banks at init, back bank after each swap; a swap mid-clear restarts it.
  always_comb begin
    w_state_nx = r_state;
    w_col_nx = r_col + CW'(1);
    w_front_nx = r_front;
    w_ovr_nx = 1'b0;
    w_clr = 2'b00;
    case (r_state)
      INIT_CLR: begin
        w_clr = 2'b11;
        if (r_col == LAST) begin
          w_state_nx = IDLE;
          w_col_nx = '0;
        end
      end
      IDLE: begin
        w_col_nx = '0;
        if (swap) begin
          w_front_nx = ~r_front;
          w_state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (swap) begin
          w_ovr_nx = 1'b1;
          w_front_nx = ~r_front;
          w_col_nx = '0;
        end else begin
          w_clr = r_front ? 2'b01 : 2'b10;
          if (r_col == LAST) begin
            w_state_nx = IDLE;
            w_col_nx = '0;
          end
        end
      end
      default: begin
        w_state_nx = INIT_CLR;
        w_col_nx = '0;
      end
    endcase
  end
  // State, bank select and the registered front-bank read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT_CLR;
      r_col <= '0;
      r_front <= 1'b0;
      r_overrun <= 1'b0;
      r_rd <= PX_CLR;
    end else begin
      r_state <= w_state_nx;
      r_col <= w_col_nx;
      r_front <= w_front_nx;
      r_overrun <= w_ovr_nx;
      r_rd <= r_front ? w_rd[1] : w_rd[0];
    end
  end
endmodule

// File: tb/tb_obj_line_buffer_pp.sv
// tb_obj_line_buffer_pp: directed table plus randomized run against a line-level reference model
module tb_obj_line_buffer_pp;
  localparam int COLS = 240;
  localparam int PMAX = 3;
  localparam int STK = 'h4000;
  logic clock = 1'b0;
  logic reset = 1'b0, swap = 1'b0, we = 1'b0, transparent = 1'b0, palettemode = 1'b0;
  logic [7:0] wcol = '0, rcol = '0;
  logic [19:0] wdata = '0;
  logic [1:0] wprio = '0;
  logic wready, busy, overrun;
  logic [19:0] rdata;
  logic [1:0] rprio;
  int n_chk = 0, n_fail = 0;
  int m_data [2][COLS];
  int m_prio [2][COLS];
  bit m_known [2][COLS];
  bit m_front = 0, m_init = 0, e_ovr = 0, e_known = 0;
  int m_left = 0, m_pos = 0, e_rdata = 0, e_rprio = PMAX;
  typedef struct {
    int col; int data; int prio; bit tr; bit pm; bit we; bit sw; bit chk; int exp_data; int exp_prio;
  } vec_t;
  vec_t vecs[$];

  obj_line_buffer_pp dut (
    .clock(clock), .reset(reset), .swap(swap), .we(we), .wcol(wcol), .wdata(wdata),
    .wprio(wprio), .transparent(transparent), .palettemode(palettemode), .wready(wready),
    .rcol(rcol), .rdata(rdata), .rprio(rprio), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_tr(input int d, input bit pm);
    return pm ? ((d & 'hFF) == 0) : ((d & 'hF) == 0);
  endfunction

  task automatic m_clear(input int b, input int c);
    m_data[b][c] = 0;
    m_prio[b][c] = PMAX;
    m_known[b][c] = 1;
  endtask

  task automatic m_write();
    int b, c, old, st;
    b = m_front ? 0 : 1;
    c = int'(wcol);
    old = m_data[b][c];
    st = (int'(wdata) | old) & STK;
    if (!transparent && !is_tr(int'(wdata), palettemode) &&
        (is_tr(old, palettemode) || int'(wprio) < m_prio[b][c])) begin
      m_data[b][c] = int'(wdata);
      m_prio[b][c] = int'(wprio);
    end
    m_data[b][c] = (m_data[b][c] & ~STK) | st;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_init = 1; m_left = COLS; m_pos = 0; m_front = 0;
      e_rdata = 0; e_rprio = PMAX; e_ovr = 0; e_known = 1;
      for (int b = 0; b < 2; b++) for (int c = 0; c < COLS; c++) m_known[b][c] = 0;
      return;
    end
    if (int'(rcol) < COLS) begin
      e_rdata = m_data[m_front][rcol];
      e_rprio = m_prio[m_front][rcol];
      e_known = m_known[m_front][rcol];
    end else begin
      e_rdata = 0; e_rprio = PMAX; e_known = 1;
    end
    e_ovr = 0;
    if (m_left == 0) begin
      if (we && int'(wcol) < COLS) m_write();
      if (swap) begin m_front = !m_front; m_left = COLS; m_pos = 0; end
    end else if (m_init) begin
      m_clear(0, m_pos); m_clear(1, m_pos);
      m_pos++; m_left--;
      if (m_left == 0) m_init = 0;
    end else if (swap) begin
      e_ovr = 1; m_front = !m_front; m_left = COLS; m_pos = 0;
    end else begin
      m_clear(m_front ? 0 : 1, m_pos);
      m_pos++; m_left--;
    end
  endtask

  task automatic compare_all();
    check("busy", busy, m_left > 0);
    check("wready", wready, m_left == 0);
    check("overrun", overrun, e_ovr);
    if (e_known) begin
      check("rdata", rdata, e_rdata);
      check("rprio", rprio, e_rprio);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      rcol = 8'(n % 256);
      step();
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int n, n_ovr, d;
    vecs.push_back('{10, 'h00012, 2, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{10, 'h00034, 1, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{10, 'h00056, 1, 0, 0, 1, 0, 1, 'h00034, 1});
    vecs.push_back('{5, 'h00010, 0, 0, 0, 1, 0, 1, 'h00000, 3});
    vecs.push_back('{6, 'h00010, 0, 0, 1, 1, 0, 1, 'h00010, 0});
    vecs.push_back('{7, 'h04001, 3, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{7, 'h00022, 0, 0, 0, 1, 0, 1, 'h04022, 0});
    vecs.push_back('{0, 'h04003, 0, 1, 0, 1, 0, 1, 'h04000, 3});
    vecs.push_back('{239, 'h00101, 1, 0, 0, 1, 0, 1, 'h00101, 1});
    vecs.push_back('{250, 'h00077, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{240, 0, 0, 0, 0, 0, 0, 1, 0, 3});
    vecs.push_back('{255, 0, 0, 0, 0, 0, 0, 1, 0, 3});
    vecs.push_back('{20, 'h00099, 2, 0, 1, 1, 1, 1, 'h00099, 2});
    reset = 1;
    step();
    check("rst_rdata", rdata, 0);
    check("rst_rprio", rprio, 3);
    check("rst_busy", busy, 1);
    check("rst_wready", wready, 0);
    step();
    reset = 0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      swap = (n == 50);
      step();
    end
    swap = 0;
    check("init_busy_cycles", n, 240);
    for (int c = 0; c < COLS; c++) begin
      rcol = 8'(c);
      step();
      check("init_rdata", rdata, 0);
      check("init_rprio", rprio, 3);
    end
    foreach (vecs[i]) begin
      wcol = 8'(vecs[i].col); wdata = 20'(vecs[i].data); wprio = 2'(vecs[i].prio);
      transparent = vecs[i].tr; palettemode = vecs[i].pm; we = vecs[i].we; swap = vecs[i].sw;
      step();
    end
    we = 0; swap = 0; transparent = 0; palettemode = 0;
    wait_idle(n);
    check("line_clear_cycles", n, 240);
    foreach (vecs[i]) begin
      if (vecs[i].chk) begin
        rcol = 8'(vecs[i].col);
        step();
        check($sformatf("tbl_rdata_c%0d", vecs[i].col), rdata, vecs[i].exp_data);
        check($sformatf("tbl_rprio_c%0d", vecs[i].col), rprio, vecs[i].exp_prio);
      end
    end
    rcol = 0;
    step();
    rcol = 10;
    #1;
    check("lat_hold", rdata, 'h04000);
    step();
    check("lat_new", rdata, 'h00034);
    swap = 1;
    step();
    swap = 0;
    we = 1; wcol = 30; wdata = 'h00777; wprio = 0;
    repeat (99) step();
    swap = 1;
    step();
    swap = 0;
    check("ovr_pulse", overrun, 1);
    n = 0; n_ovr = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step();
      n_ovr += int'(overrun);
    end
    we = 0;
    check("ovr_busy_cycles", n, 240);
    check("ovr_single_pulse", n_ovr, 0);
    swap = 1;
    step();
    swap = 0;
    wait_idle(n);
    rcol = 30;
    step();
    check("clear_write_ignored_d", rdata, 0);
    check("clear_write_ignored_p", rprio, 3);
    for (int i = 0; i < 2500; i++) begin
      reset = (i == 1200 || i == 1201);
      swap = ($urandom_range(0, 299) == 0) || (i > 1201 && i < 1300 && $urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      wcol = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      rcol = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      d = int'($urandom_range(0, 'hFFFFF));
      if ($urandom_range(0, 2) == 0) d = d & 'hFFF00;
      else if ($urandom_range(0, 3) == 0) d = d & 'hFFFF0;
      wdata = 20'(d);
      wprio = 2'($urandom_range(0, 3));
      transparent = ($urandom_range(0, 7) == 0);
      palettemode = 1'($urandom_range(0, 1));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
